// File: rtl/main_control_fsm_pkg.sv
// Shared control-unit encodings: opcodes, FSM states and datapath mux codes.
package main_control_fsm_pkg;

   localparam int unsigned OP_W    = 7;
   localparam int unsigned STATE_W = 4;
   localparam int unsigned SEL_W   = 2;

   localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXECUTER = 4'd6,
      ST_EXECUTEI = 4'd7,
      ST_ALUWB    = 4'd8,
      ST_BEQ      = 4'd9,
      ST_JAL      = 4'd10,
      ST_ILLEGAL  = 4'd11
   } state_e;

   localparam logic [SEL_W-1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALU_OP_RTYPE = 2'b10;
   localparam logic [SEL_W-1:0] ALU_OP_ITYPE = 2'b11;

   localparam logic [SEL_W-1:0] IMM_I = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J = 2'b11;

   localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
   localparam logic [SEL_W-1:0] RES_RDATA   = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALURES  = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC     = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC  = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1    = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b10;

   // Per-state control word before write-enable gating.
   typedef struct packed {
      logic             adr_src;
      logic             mem_write;
      logic             ir_write;
      logic [SEL_W-1:0] result_src;
      logic [SEL_W-1:0] alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic [SEL_W-1:0] alu_op;
      logic             reg_write;
      logic             pc_update;
      logic             branch;
   } ctrl_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath bundle: opcode/flags in, mux selects and enables out.
interface main_control_fsm_if;
   import main_control_fsm_pkg::*;

   logic [OP_W-1:0]    Op;
   logic               Zero;
   logic               mem_ready;
   logic               PCWrite;
   logic               AdrSrc;
   logic               MemWrite;
   logic               IRWrite;
   logic [SEL_W-1:0]   ResultSrc;
   logic [SEL_W-1:0]   ALUSrcA;
   logic [SEL_W-1:0]   ALUSrcB;
   logic [SEL_W-1:0]   ALU_Op;
   logic [SEL_W-1:0]   ImmSrc;
   logic               RegWrite;
   logic               illegal;
   logic [STATE_W-1:0] state_dbg;

   modport master (
      input  Op, Zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALU_Op, ImmSrc, RegWrite, illegal, state_dbg
   );

   modport slave (
      output Op, Zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALU_Op, ImmSrc, RegWrite, illegal, state_dbg
   );
endinterface

// File: rtl/main_control_fsm_imm_src_decoder.sv
// Opcode -> immediate format select, independent of FSM state.
module main_control_fsm_imm_src_decoder
   import main_control_fsm_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   output logic [SEL_W-1:0] imm_src_c
);

   // Immediate format per opcode; unknown opcodes fall back to I-format.
   always_comb begin
      imm_src_c = IMM_I;
      case (op)
         OP_SW:   imm_src_c = IMM_S;
         OP_BEQ:  imm_src_c = IMM_B;
         OP_JAL:  imm_src_c = IMM_J;
         default: imm_src_c = IMM_I;
      endcase
   end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main controller: state sequencing plus Moore control decode.
module main_control_fsm
   import main_control_fsm_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1
)(
   input  logic                clk,
   input  logic                reset,
   main_control_fsm_if.master  bus
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   mem_go;
   ctrl_t  ctrl;
   logic   [SEL_W-1:0] imm_src_c;

   // Memory states advance only when the access completes, unless memory is single-cycle.
   assign mem_go = !USE_MEM_READY || bus.mem_ready;

   // Next-state and sticky illegal flag.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q | (state_q == ST_ILLEGAL);
      case (state_q)
         ST_FETCH:    if (mem_go) state_d = ST_DECODE;
         ST_DECODE: begin
            case (bus.Op)
               OP_LW, OP_SW: state_d = ST_MEMADR;
               OP_R:         state_d = ST_EXECUTER;
               OP_I:         state_d = ST_EXECUTEI;
               OP_BEQ:       state_d = ST_BEQ;
               OP_JAL:       state_d = ST_JAL;
               default:      state_d = ST_ILLEGAL;
            endcase
         end
         ST_MEMADR:   state_d = (bus.Op == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
         ST_MEMREAD:  if (mem_go) state_d = ST_MEMWB;
         ST_MEMWB:    state_d = ST_FETCH;
         ST_MEMWRITE: if (mem_go) state_d = ST_FETCH;
         ST_EXECUTER: state_d = ST_ALUWB;
         ST_EXECUTEI: state_d = ST_ALUWB;
         ST_ALUWB:    state_d = ST_FETCH;
         ST_BEQ:      state_d = ST_FETCH;
         ST_JAL:      state_d = ST_ALUWB;
         ST_ILLEGAL:  state_d = ST_ILLEGAL;
         default:     state_d = ST_FETCH;
      endcase
   end

   // State and flag registers; reset abandons any in-flight instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Moore control word per state; everything not named stays 0.
   always_comb begin
      ctrl = '0;
      case (state_q)
         ST_FETCH: begin
            ctrl.ir_write   = mem_go;
            ctrl.pc_update  = mem_go;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.alu_op     = ALU_OP_ADD;
            ctrl.result_src = RES_ALURES;
         end
         ST_DECODE: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_IMM;
         end
         ST_MEMADR: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_IMM;
         end
         ST_MEMREAD: begin
            ctrl.adr_src    = 1'b1;
            ctrl.result_src = RES_ALUOUT;
         end
         ST_MEMWB: begin
            ctrl.result_src = RES_RDATA;
            ctrl.reg_write  = 1'b1;
         end
         ST_MEMWRITE: begin
            ctrl.adr_src    = 1'b1;
            ctrl.mem_write  = 1'b1;
         end
         ST_EXECUTER: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.alu_op     = ALU_OP_RTYPE;
         end
         ST_EXECUTEI: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_IMM;
            ctrl.alu_op     = ALU_OP_ITYPE;
         end
         ST_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
         end
         ST_BEQ: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.alu_op     = ALU_OP_SUB;
            ctrl.branch     = 1'b1;
         end
         ST_JAL: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.pc_update  = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   main_control_fsm_imm_src_decoder u_imm_src (
      .op        (bus.Op),
      .imm_src_c (imm_src_c)
   );

   // Drive the bus; write enables are held off for as long as reset is high.
   always_comb begin
      bus.PCWrite   = !reset && (ctrl.pc_update || (ctrl.branch && bus.Zero));
      bus.IRWrite   = !reset && ctrl.ir_write;
      bus.MemWrite  = !reset && ctrl.mem_write;
      bus.RegWrite  = !reset && ctrl.reg_write;
      bus.AdrSrc    = ctrl.adr_src;
      bus.ResultSrc = ctrl.result_src;
      bus.ALUSrcA   = ctrl.alu_src_a;
      bus.ALUSrcB   = ctrl.alu_src_b;
      bus.ALU_Op    = ctrl.alu_op;
      bus.ImmSrc    = imm_src_c;
      bus.illegal   = illegal_q;
      bus.state_dbg = state_q;
   end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scoreboard bench: driver queues expected per-cycle control vectors, monitor compares.
module tb_main_control_fsm;
   import main_control_fsm_pkg::*;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                          S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                          S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                          S_BEQ = 4'd9, S_JAL = 4'd10, S_ILL = 4'd11;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   int   cyc0 = 0;
   int   cyc1 = 0;

   logic [19:0] q0[$];
   logic [19:0] q1[$];

   main_control_fsm_if if0();
   main_control_fsm_if if1();

   main_control_fsm #(.USE_MEM_READY(1'b1)) u_dut0 (.clk(clk), .reset(rst), .bus(if0));
   main_control_fsm #(.USE_MEM_READY(1'b0)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));

   always #5 clk = ~clk;

   wire logic [19:0] act0 = {if0.state_dbg, if0.PCWrite, if0.AdrSrc, if0.MemWrite, if0.IRWrite,
                             if0.ResultSrc, if0.ALUSrcA, if0.ALUSrcB, if0.ALU_Op, if0.ImmSrc,
                             if0.RegWrite, if0.illegal};
   wire logic [19:0] act1 = {if1.state_dbg, if1.PCWrite, if1.AdrSrc, if1.MemWrite, if1.IRWrite,
                             if1.ResultSrc, if1.ALUSrcA, if1.ALUSrcB, if1.ALU_Op, if1.ImmSrc,
                             if1.RegWrite, if1.illegal};

   // Hand-written per-state output table.
   function automatic logic [19:0] exp_vec(bit use_mr, logic [3:0] st, logic [6:0] op,
                                           logic zero, logic mr, logic r, logic ill);
      logic go;
      logic pcw, adr, mw, irw, rw;
      logic [1:0] rs, a, b, ao, imm;
      go = !use_mr || mr;
      pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
      rs = 2'b00; a = 2'b00; b = 2'b00; ao = 2'b00;
      case (op)
         7'b0100011: imm = 2'b01;
         7'b1100011: imm = 2'b10;
         7'b1101111: imm = 2'b11;
         default:    imm = 2'b00;
      endcase
      case (st)
         S_FETCH:    begin irw = go; pcw = go; b = 2'b10; rs = 2'b10; end
         S_DECODE:   begin a = 2'b01; b = 2'b01; end
         S_MEMADR:   begin a = 2'b10; b = 2'b01; end
         S_MEMREAD:  begin adr = 1; end
         S_MEMWB:    begin rs = 2'b01; rw = 1; end
         S_MEMWRITE: begin adr = 1; mw = 1; end
         S_EXECR:    begin a = 2'b10; ao = 2'b10; end
         S_EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b11; end
         S_ALUWB:    begin rw = 1; end
         S_BEQ:      begin a = 2'b10; ao = 2'b01; pcw = zero; end
         S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
         default:    ;
      endcase
      if (r) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
      return {st, pcw, adr, mw, irw, rs, a, b, ao, imm, rw, ill};
   endfunction

   task automatic check(string name, logic [19:0] got, logic [19:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%05h expected=%05h", name, got, want);
      end
   endtask

   // One cycle of stimulus: drive inputs after the edge and queue the expected outputs.
   task automatic step(int d, logic [3:0] st, logic [6:0] op, logic zero, logic mr,
                       logic r, logic ill);
      @(posedge clk);
      #1;
      rst = r;
      if (d == 0) begin
         if0.Op = op; if0.Zero = zero; if0.mem_ready = mr;
         q0.push_back(exp_vec(1'b1, st, op, zero, mr, r, ill));
      end else begin
         if1.Op = op; if1.Zero = zero; if1.mem_ready = mr;
         q1.push_back(exp_vec(1'b0, st, op, zero, mr, r, ill));
      end
   endtask

   // Monitor: compare every queued expectation against the sampled outputs.
   always @(negedge clk) begin
      if (q0.size() > 0) begin
         check($sformatf("dut0_cycle%0d", cyc0), act0, q0.pop_front());
         cyc0++;
      end
      if (q1.size() > 0) begin
         check($sformatf("dut1_cycle%0d", cyc1), act1, q1.pop_front());
         cyc1++;
      end
   end

   initial begin
      rst = 1'b1;
      if0.Op = OP_R; if0.Zero = 1'b0; if0.mem_ready = 1'b1;
      if1.Op = OP_R; if1.Zero = 1'b0; if1.mem_ready = 1'b1;
      repeat (2) @(posedge clk);

      // reset held: FETCH values with write enables off
      step(0, S_FETCH, OP_R, 0, 1, 1, 0);
      // R-type
      step(0, S_FETCH,  OP_R, 0, 1, 0, 0);
      step(0, S_DECODE, OP_R, 0, 1, 0, 0);
      step(0, S_EXECR,  OP_R, 0, 1, 0, 0);
      step(0, S_ALUWB,  OP_R, 0, 1, 0, 0);
      // I-type
      step(0, S_FETCH,  OP_I, 0, 1, 0, 0);
      step(0, S_DECODE, OP_I, 0, 1, 0, 0);
      step(0, S_EXECI,  OP_I, 0, 1, 0, 0);
      step(0, S_ALUWB,  OP_I, 0, 1, 0, 0);
      // lw with two wait cycles in MEMREAD
      step(0, S_FETCH,   OP_LW, 0, 1, 0, 0);
      step(0, S_DECODE,  OP_LW, 0, 1, 0, 0);
      step(0, S_MEMADR,  OP_LW, 0, 1, 0, 0);
      step(0, S_MEMREAD, OP_LW, 0, 0, 0, 0);
      step(0, S_MEMREAD, OP_LW, 0, 0, 0, 0);
      step(0, S_MEMREAD, OP_LW, 0, 1, 0, 0);
      step(0, S_MEMWB,   OP_LW, 0, 1, 0, 0);
      // beq taken, with a fetch stall first
      step(0, S_FETCH,  OP_BEQ, 1, 0, 0, 0);
      step(0, S_FETCH,  OP_BEQ, 1, 1, 0, 0);
      step(0, S_DECODE, OP_BEQ, 1, 1, 0, 0);
      step(0, S_BEQ,    OP_BEQ, 1, 1, 0, 0);
      // beq not taken
      step(0, S_FETCH,  OP_BEQ, 0, 1, 0, 0);
      step(0, S_DECODE, OP_BEQ, 0, 1, 0, 0);
      step(0, S_BEQ,    OP_BEQ, 0, 1, 0, 0);
      // jal
      step(0, S_FETCH,  OP_JAL, 0, 1, 0, 0);
      step(0, S_DECODE, OP_JAL, 0, 1, 0, 0);
      step(0, S_JAL,    OP_JAL, 0, 1, 0, 0);
      step(0, S_ALUWB,  OP_JAL, 0, 1, 0, 0);
      // sw stalled in MEMWRITE, then reset asserted between clock edges
      step(0, S_FETCH,    OP_SW, 0, 1, 0, 0);
      step(0, S_DECODE,   OP_SW, 0, 1, 0, 0);
      step(0, S_MEMADR,   OP_SW, 0, 1, 0, 0);
      step(0, S_MEMWRITE, OP_SW, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_memwrite", 20'(if0.MemWrite), 20'd0);
      check("async_rst_state", 20'(if0.state_dbg), 20'(S_FETCH));
      step(0, S_FETCH, OP_SW, 0, 1, 1, 0);
      // unsupported opcode: absorbing, flag sticky
      step(0, S_FETCH,  OP_BAD, 0, 1, 0, 0);
      step(0, S_DECODE, OP_BAD, 0, 1, 0, 0);
      step(0, S_ILL,    OP_BAD, 0, 1, 0, 0);
      step(0, S_ILL,    OP_R,   1, 1, 0, 1);
      step(0, S_ILL,    OP_LW,  0, 1, 0, 1);
      step(0, S_ILL,    OP_JAL, 0, 0, 0, 1);
      step(0, S_FETCH,  OP_R,   0, 1, 1, 0);

      // single-cycle memory: mem_ready low never stalls
      step(1, S_FETCH,    OP_SW, 0, 0, 0, 0);
      step(1, S_DECODE,   OP_SW, 0, 0, 0, 0);
      step(1, S_MEMADR,   OP_SW, 0, 0, 0, 0);
      step(1, S_MEMWRITE, OP_SW, 0, 0, 0, 0);
      step(1, S_FETCH,    OP_LW, 0, 0, 0, 0);
      step(1, S_DECODE,   OP_LW, 0, 0, 0, 0);
      step(1, S_MEMADR,   OP_LW, 0, 0, 0, 0);
      step(1, S_MEMREAD,  OP_LW, 0, 0, 0, 0);
      step(1, S_MEMWB,    OP_LW, 0, 0, 0, 0);
      step(1, S_FETCH,    OP_R,  0, 0, 0, 0);

      @(negedge clk);
      #1;
      check("scoreboard_drained", 20'(q0.size() + q1.size()), 20'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
